// File: rtl/alu_rr_scheduler_if.sv
// Bundle between the requesting units, the shared ALU and the round-robin scheduler.
// The scheduler takes the slave view; requesters and the ALU model take the master view.
interface alu_rr_scheduler_if #(
  parameter int DATA_W = 32,
  parameter int OP_W   = 3
);
  logic [3:0]          req;
  logic [4*OP_W-1:0]   op_in;
  logic [4*DATA_W-1:0] a_in;
  logic [4*DATA_W-1:0] b_in;
  logic [OP_W-1:0]     alu_op;
  logic [DATA_W-1:0]   alu_a;
  logic [DATA_W-1:0]   alu_b;
  logic                alu_start;
  logic [DATA_W-1:0]   alu_result;
  logic [3:0]          grant;
  logic [3:0]          done;
  logic [DATA_W-1:0]   result;
  logic                busy;

  modport master (
    output req, op_in, a_in, b_in, alu_result,
    input  alu_op, alu_a, alu_b, alu_start, grant, done, result, busy
  );

  modport slave (
    input  req, op_in, a_in, b_in, alu_result,
    output alu_op, alu_a, alu_b, alu_start, grant, done, result, busy
  );
endinterface

// File: rtl/alu_rr_scheduler.sv
// Round-robin scheduler sharing one ALU among four requesters: arbitrate, latch operands,
// launch one fixed-latency operation and return its result with a one-cycle done pulse.
module alu_rr_scheduler #(
  parameter int DATA_W  = 32,
  parameter int OP_W    = 3,
  parameter int ALU_LAT = 1
) (
  input  logic                clk,
  input  logic                rst,
  alu_rr_scheduler_if.slave   bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    EXEC  = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [3:0] CNT_LOAD = 4'(ALU_LAT - 1);

  state_t              state_r, state_s;
  logic [1:0]          ptr_r, ptr_s;
  logic [1:0]          idx_r, idx_s;
  logic [3:0]          cnt_r, cnt_s;
  logic [3:0]          grant_r, grant_s;
  logic [3:0]          done_r, done_s;
  logic                start_r, start_s;
  logic                busy_r, busy_s;
  logic [OP_W-1:0]     op_r, op_s;
  logic [DATA_W-1:0]   a_r, a_s;
  logic [DATA_W-1:0]   b_r, b_s;
  logic [DATA_W-1:0]   result_r, result_s;
  logic [1:0]          win_s;
  logic                found_s;

  // Round-robin pick: first requester set in order ptr+1, ptr+2, ptr+3, ptr
  always_comb begin
    win_s   = ptr_r;
    found_s = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      win_s   = (!found_s && bus.req[2'(ptr_r + 2'(k))]) ? 2'(ptr_r + 2'(k)) : win_s;
      found_s = found_s | bus.req[2'(ptr_r + 2'(k))];
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE:    state_s = found_s ? ISSUE : IDLE;
      ISSUE:   state_s = EXEC;
      EXEC:    state_s = (cnt_r == 4'd0) ? DONE : EXEC;
      DONE:    state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // Next values of the registered outputs; everything leaves through flops
  always_comb begin
    ptr_s    = ptr_r;
    idx_s    = idx_r;
    cnt_s    = cnt_r;
    grant_s  = grant_r;
    op_s     = op_r;
    a_s      = a_r;
    b_s      = b_r;
    result_s = result_r;
    start_s  = 1'b0;
    done_s   = 4'b0000;
    busy_s   = (state_s != IDLE);
    case (state_r)
      IDLE: begin
        if (found_s) begin
          idx_s   = win_s;
          ptr_s   = win_s;
          grant_s = 4'b0001 << win_s;
          op_s    = bus.op_in[int'(win_s)*OP_W +: OP_W];
          a_s     = bus.a_in[int'(win_s)*DATA_W +: DATA_W];
          b_s     = bus.b_in[int'(win_s)*DATA_W +: DATA_W];
          start_s = 1'b1;
        end else begin
          grant_s = 4'b0000;
        end
      end
      ISSUE: cnt_s = CNT_LOAD;
      EXEC: begin
        if (cnt_r == 4'd0) begin
          result_s = bus.alu_result;
          done_s   = 4'b0001 << idx_r;
        end else begin
          cnt_s = cnt_r - 4'd1;
        end
      end
      DONE:    grant_s = 4'b0000;
      default: grant_s = 4'b0000;
    endcase
  end

  // Output and datapath registers; ptr resets to 3 so requester 0 wins first
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_r    <= 2'd3;
      idx_r    <= 2'd0;
      cnt_r    <= 4'd0;
      grant_r  <= 4'b0000;
      done_r   <= 4'b0000;
      start_r  <= 1'b0;
      busy_r   <= 1'b0;
      op_r     <= '0;
      a_r      <= '0;
      b_r      <= '0;
      result_r <= '0;
    end else begin
      ptr_r    <= ptr_s;
      idx_r    <= idx_s;
      cnt_r    <= cnt_s;
      grant_r  <= grant_s;
      done_r   <= done_s;
      start_r  <= start_s;
      busy_r   <= busy_s;
      op_r     <= op_s;
      a_r      <= a_s;
      b_r      <= b_s;
      result_r <= result_s;
    end
  end

  assign bus.alu_op    = op_r;
  assign bus.alu_a     = a_r;
  assign bus.alu_b     = b_r;
  assign bus.alu_start = start_r;
  assign bus.grant     = grant_r;
  assign bus.done      = done_r;
  assign bus.result    = result_r;
  assign bus.busy      = busy_r;

endmodule

// File: tb/tb_alu_rr_scheduler.sv
// Bench for alu_rr_scheduler: two instances (ALU latency 1 and 4) share the requester
// stimulus and are compared every cycle against a timestamp-based transaction model.
module tb_alu_rr_scheduler;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [3:0]   req = 4'b0000;
  logic [11:0]  op_in = 12'd0;
  logic [127:0] a_in = 128'd0;
  logic [127:0] b_in = 128'd0;
  logic [31:0]  alu_res [2];

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  always #5 clk = ~clk;

  alu_rr_scheduler_if #(.DATA_W(32), .OP_W(3)) bus1 ();
  alu_rr_scheduler_if #(.DATA_W(32), .OP_W(3)) bus4 ();

  alu_rr_scheduler #(.DATA_W(32), .OP_W(3), .ALU_LAT(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));
  alu_rr_scheduler #(.DATA_W(32), .OP_W(3), .ALU_LAT(4)) dut4 (.clk(clk), .rst(rst), .bus(bus4));

  assign bus1.req = req;   assign bus4.req = req;
  assign bus1.op_in = op_in; assign bus4.op_in = op_in;
  assign bus1.a_in = a_in; assign bus4.a_in = a_in;
  assign bus1.b_in = b_in; assign bus4.b_in = b_in;
  assign bus1.alu_result = alu_res[0];
  assign bus4.alu_result = alu_res[1];

  logic [3:0]  o_grant [2];
  logic [3:0]  o_done  [2];
  logic        o_start [2];
  logic        o_busy  [2];
  logic [2:0]  o_op    [2];
  logic [31:0] o_a     [2];
  logic [31:0] o_b     [2];
  logic [31:0] o_res   [2];
  assign o_grant[0] = bus1.grant;     assign o_grant[1] = bus4.grant;
  assign o_done[0]  = bus1.done;      assign o_done[1]  = bus4.done;
  assign o_start[0] = bus1.alu_start; assign o_start[1] = bus4.alu_start;
  assign o_busy[0]  = bus1.busy;      assign o_busy[1]  = bus4.busy;
  assign o_op[0]    = bus1.alu_op;    assign o_op[1]    = bus4.alu_op;
  assign o_a[0]     = bus1.alu_a;     assign o_a[1]     = bus4.alu_a;
  assign o_b[0]     = bus1.alu_b;     assign o_b[1]     = bus4.alu_b;
  assign o_res[0]   = bus1.result;    assign o_res[1]   = bus4.result;

  // Transaction model: an accepted operation at cycle acc owns the ALU through acc+lat+2
  int          lat     [2] = '{1, 4};
  bit          m_act   [2];
  int          m_acc   [2];
  int          m_owner [2];
  int          m_ptr   [2];
  logic [2:0]  m_op    [2];
  logic [31:0] m_a     [2];
  logic [31:0] m_b     [2];
  logic [31:0] m_res   [2];

  function automatic logic [31:0] alu_fn(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      3'd0:    return a + b;
      3'd1:    return a - b;
      3'd2:    return a & b;
      3'd3:    return a | b;
      3'd4:    return a ^ b;
      3'd5:    return a << b[4:0];
      3'd6:    return a >> b[4:0];
      default: return b;
    endcase
  endfunction

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      if (n_fail <= 40)
        $display("FAIL %s @cycle %0d: got %0h, expected %0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_act[d] = 1'b0; m_acc[d] = 0; m_owner[d] = 0; m_ptr[d] = 3;
      m_op[d] = 3'd0; m_a[d] = 32'd0; m_b[d] = 32'd0; m_res[d] = 32'd0;
    end
  endtask

  // One clock cycle: play the ALU, compare outputs mid-cycle, then advance the model
  task automatic step();
    for (int d = 0; d < 2; d++) begin
      if (m_act[d] && (cyc - m_acc[d]) == lat[d] + 1)
        alu_res[d] = alu_fn(m_op[d], m_a[d], m_b[d]);
      else
        alu_res[d] = $urandom;
    end
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      int         k;
      logic [3:0] eg, ed;
      logic       es, eb;
      k  = cyc - m_acc[d];
      eg = m_act[d] ? (4'b0001 << m_owner[d]) : 4'b0000;
      eb = m_act[d];
      es = m_act[d] && (k == 1);
      ed = (m_act[d] && k == lat[d] + 2) ? eg : 4'b0000;
      check_val($sformatf("d%0d grant", d), 32'(o_grant[d]), 32'(eg));
      check_val($sformatf("d%0d done", d), 32'(o_done[d]), 32'(ed));
      check_val($sformatf("d%0d alu_start", d), 32'(o_start[d]), 32'(es));
      check_val($sformatf("d%0d busy", d), 32'(o_busy[d]), 32'(eb));
      check_val($sformatf("d%0d alu_op", d), 32'(o_op[d]), 32'(m_op[d]));
      check_val($sformatf("d%0d alu_a", d), o_a[d], m_a[d]);
      check_val($sformatf("d%0d alu_b", d), o_b[d], m_b[d]);
      check_val($sformatf("d%0d result", d), o_res[d], m_res[d]);
    end
    for (int d = 0; d < 2; d++) begin
      int k;
      k = cyc - m_acc[d];
      if (rst) begin
        m_act[d] = 1'b0; m_ptr[d] = 3;
        m_op[d] = 3'd0; m_a[d] = 32'd0; m_b[d] = 32'd0; m_res[d] = 32'd0;
      end else if (m_act[d]) begin
        if (k == lat[d] + 1) m_res[d] = alu_fn(m_op[d], m_a[d], m_b[d]);
        if (k >= lat[d] + 2) m_act[d] = 1'b0;
      end else if (req != 4'b0000) begin
        bit got;
        got = 1'b0;
        for (int j = 1; j <= 4; j++) begin
          int c;
          c = (m_ptr[d] + j) % 4;
          if (!got && req[c]) begin
            got = 1'b1;
            m_owner[d] = c;
          end
        end
        m_ptr[d] = m_owner[d];
        m_op[d]  = op_in[m_owner[d]*3 +: 3];
        m_a[d]   = a_in[m_owner[d]*32 +: 32];
        m_b[d]   = b_in[m_owner[d]*32 +: 32];
        m_act[d] = 1'b1;
        m_acc[d] = cyc;
      end
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic rand_operands();
    op_in = 12'($urandom);
    a_in  = {$urandom, $urandom, $urandom, $urandom};
    b_in  = {$urandom, $urandom, $urandom, $urandom};
  endtask

  initial begin
    alu_res[0] = 32'd0;
    alu_res[1] = 32'd0;
    rand_operands();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();

    // Single request from requester 0
    op_in[2:0] = 3'd2; a_in[31:0] = 32'd5; b_in[31:0] = 32'd7;
    req = 4'b0001;
    run(4);
    req = 4'b0000;
    run(6);

    // All four requesting continuously: rotation 0,1,2,3,0
    rand_operands();
    req = 4'b1111;
    run(30);
    req = 4'b0000;
    run(8);

    // Grant to 2, then 0 and 2 requesting
    req = 4'b0100;
    run(1);
    req = 4'b0000;
    run(8);
    req = 4'b0101;
    run(12);
    req = 4'b0000;
    run(8);

    // Requester 1 drops req and changes operands right after being accepted
    rand_operands();
    req = 4'b0010;
    run(1);
    req = 4'b0000;
    rand_operands();
    run(9);

    // Reset while the operation is executing, then 3 and 0 together
    req = 4'b0001;
    run(3);
    rst = 1'b1; req = 4'b0000;
    run(1);
    rst = 1'b0; req = 4'b1001;
    run(10);
    req = 4'b0000;
    run(8);

    // Random traffic with occasional resets
    for (int i = 0; i < 3000; i++) begin
      rand_operands();
      req = ($urandom_range(0, 3) == 0) ? 4'b0000 : 4'($urandom_range(1, 15));
      rst = ($urandom_range(0, 99) == 0);
      step();
    end
    rst = 1'b0;
    req = 4'b0000;
    run(10);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_rr_scheduler.md
# alu_rr_scheduler

Round-robin scheduler sharing one 32-bit ALU among four requesters. Arbitrates pending requests, latches the winner's opcode and operands, sequences one ALU operation with a fixed latency, and returns the result with a one-cycle completion pulse. Sits between the requesting units and the ALU datapath; the 3-bit opcode it drives feeds the ALU's 3-to-8 function decode, and its one-hot grant comes from a 2-to-4 decode of the winning index.

## Interface
Parameters:
- DATA_W, 32, operand/result width
- OP_W, 3, opcode width (8 ALU functions)
- ALU_LAT, 1, cycles from alu_start to valid alu_result (legal 1..15)

Ports:
- clk  in  1  rising-edge clock, single domain
- rst  in  1  synchronous, active-high reset
- req  in  4  per-requester request; held high with operands stable until done
- op_in  in  4*OP_W  opcodes, requester i at [i*OP_W +: OP_W]
- a_in  in  4*DATA_W  operand A, requester i at [i*DATA_W +: DATA_W]
- b_in  in  4*DATA_W  operand B, same packing
- alu_op  out  OP_W  opcode to ALU
- alu_a, alu_b  out  DATA_W  operands to ALU
- alu_start  out  1  one-cycle launch strobe
- alu_result  in  DATA_W  ALU output, valid ALU_LAT cycles after alu_start
- grant  out  4  one-hot owner of the ALU
- done  out  4  one-hot, one-cycle completion pulse
- result  out  DATA_W  captured result, valid while done nonzero and held until next capture
- busy  out  1  high whenever state is not IDLE

## Operation
- States: IDLE, ISSUE, EXEC, DONE.
- IDLE: if req != 0, select winner by round robin, register idx and grant, latch op/a/b of winner into alu_op/alu_a/alu_b, update ptr=idx, go ISSUE. Else stay.
- Round robin: search order ptr+1, ptr+2, ptr+3, ptr (mod 4); first set bit wins. ptr resets to 3 so requester 0 has first priority.
- ISSUE: alu_start=1; load cnt=ALU_LAT-1; go EXEC.
- EXEC: if cnt==0 capture alu_result into result, go DONE; else cnt--.
- DONE: done[idx]=1, grant still asserted; next state IDLE, grant cleared on exit.
- Operands are latched in IDLE; later changes to req/op_in/a_in/b_in do not affect the operation in flight.
- req dropped mid-operation: operation still completes and done still pulses.
- Requester must drop req on the cycle after seeing done; a req still high in IDLE is a new request.
- Reset mid-operation: abandon operation, no done pulse, all state cleared.
- No arithmetic performed here; opcode and operands pass through unmodified.

## Timing
- Reset values: state IDLE, ptr 3, cnt 0, grant 0, done 0, alu_start 0, alu_op 0, alu_a 0, alu_b 0, result 0, busy 0.
- All outputs registered; none combinationally dependent on req.
- req sampled in IDLE at cycle T: grant, alu_op/a/b valid and alu_start high in T+1; EXEC T+2..T+1+ALU_LAT; result capture at end of T+1+ALU_LAT; done and result valid in T+2+ALU_LAT.
- Request-to-done latency ALU_LAT+2 cycles; back-to-back throughput one operation per ALU_LAT+3 cycles.
- alu_start exactly one cycle per granted operation; done exactly one cycle, bit matches grant.
- busy high from T+1 through the DONE cycle inclusive.

## Test plan
- Reset then req=4'b0001, op_in[0]=3'd2, a=5, b=7 (ALU_LAT=1) -> alu_start in T+1 with alu_op=2, alu_a=5, alu_b=7; done=4'b0001 and result=model value in T+3; grant=0 in T+4.
- req=4'b1111 held, re-raised after each done -> grants in order 0001, 0010, 0100, 1000, 0001; each done matches its grant.
- After grant to requester 2, req=4'b0101 -> next grant 0001 (search 3, 0); then with req=4'b0101 again -> 0100.
- Requester 1 drops req and changes a_in in the cycle after grant -> operation completes with original operands, done=4'b0010.
- ALU_LAT=4, single request at T -> alu_start T+1, done T+6, busy high T+1..T+6.
- rst asserted in EXEC -> next cycle all outputs at reset values, no done pulse; subsequent req=4'b1000 and req=4'b0001 together -> requester 0 wins.
